// File: rtl/alu_div_pkg.sv
// -----------------------------------------------------------------------------
// alu_div_pkg
// Shared definitions for the iterative divider core:
//   - default operand width / iteration-counter width
//   - operation encodings (DIV, DIVU, REM, REMU)
//   - controller state encoding
//   - small decode helpers for the op field
// No ports (package).
// -----------------------------------------------------------------------------
package alu_div_pkg;

  localparam int DEFAULT_W = 32;
  localparam int DEFAULT_C = 6;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } div_state_e;

  // op[0] = 0 selects the signed flavour (DIV / REM).
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // op[1] = 1 selects the remainder result (REM / REMU).
  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/alu_div_step.sv
// -----------------------------------------------------------------------------
// alu_div_step
// One combinational restoring-division iteration on the shift/subtract
// accumulator.  Accumulator layout (AW = 2W+5 bits):
//   [2W+4:W+3]  partial remainder (W+2 bits)
//   [W+2:3]     dividend bits still to consume / quotient bits produced
//   [2:0]       always zero
// Iteration: shift left by one, subtract the divisor magnitude from the
// upper field, keep the difference and write a 1 into bit 3 when it is
// non-negative, otherwise keep the shifted value (bit 3 stays 0).
//
// Ports:
//   accum_in   [2W+3:0]  current accumulator without its top bit (the top
//                        bit is always 0 between iterations and is shifted out)
//   divisor    [W-1:0]   divisor magnitude
//   accum_out  [2W+4:0]  accumulator after this iteration
// -----------------------------------------------------------------------------
module alu_div_step #(
  parameter int W = 32
) (
  input  logic [2*W+3:0] accum_in,
  input  logic [W-1:0]   divisor,
  output logic [2*W+4:0] accum_out
);

  localparam int AW = 2*W + 5;

  logic [AW-1:0] shifted;
  logic [W+1:0]  trial;

  always_comb begin
    shifted   = {accum_in, 1'b0};
    // Both operands are below 2^(W+1), so a W+2-bit difference carries a
    // valid sign in its MSB and a magnitude of 2^(W-1) never wraps.
    trial     = shifted[AW-1:W+3] - {2'b00, divisor};
    accum_out = shifted;
    if (!trial[W+1]) begin
      accum_out[AW-1:W+3] = trial;
      accum_out[3]        = 1'b1;
    end
  end

endmodule

// File: rtl/alu_div_core.sv
// -----------------------------------------------------------------------------
// alu_div_core
// Multi-cycle restoring divider for DIV / DIVU / REM / REMU.  The core works on
// operand magnitudes and reports the sign corrections in div_sbit; the final
// negation and result selection happen downstream.
//
// Build option: define DIV_SIGNED_EN to enable signed DIV/REM handling
// (magnitude conversion, sign bits, overflow detection).  Without it every
// op is treated as unsigned.
//
// Sequence: IDLE -> LOAD -> RUN (W cycles) -> DONE -> IDLE.
// Divide-by-zero and signed overflow go LOAD -> DONE directly.
//
// Ports:
//   clk           clock, rising edge
//   a_rst         asynchronous active-high reset
//   start         one-cycle request, sampled only in IDLE
//   op[1:0]       00 DIV, 01 DIVU, 10 REM, 11 REMU
//   op_a, op_b    dividend / divisor (W bits)
//   load          high during the LOAD cycle (accumulator just initialised)
//   accum         shift/subtract accumulator (2W+5 bits); after the run the
//                 quotient magnitude sits in [W+2:3] and the remainder
//                 magnitude in [2W+3:W+4] (i.e. [2W+4:W+3] reads as 2x rem)
//   div_sbit      [1] negate remainder, [0] negate quotient
//   div_zero      divisor was zero (latched)
//   div_overflow  signed min / -1 (latched)
//   div_res_sel   1 = remainder op (latched op[1])
//   dact, busy    high from LOAD through DONE
// -----------------------------------------------------------------------------
module alu_div_core
  import alu_div_pkg::*;
#(
  parameter int W = DEFAULT_W,
  parameter int C = DEFAULT_C
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [W-1:0]     op_a,
  input  logic [W-1:0]     op_b,
  output logic             load,
  output logic [2*(W+2):0] accum,
  output logic [1:0]       div_sbit,
  output logic             div_zero,
  output logic             div_overflow,
  output logic             div_res_sel,
  output logic             dact,
  output logic             busy
);

  localparam int AW = 2*W + 5;

  div_state_e     state_reg, state_next;
  logic [C-1:0]   count_reg;
  logic [AW-1:0]  accum_reg;
  logic [AW-1:0]  step_out;
  logic [W-1:0]   mag_b_reg;
  logic [1:0]     sbit_reg;
  logic           zero_reg;
  logic           ovf_reg;
  logic           res_sel_reg;

  // Operand conditioning (combinational, sampled on the accepting edge).
  logic           sign_a;
  logic           sign_b;
  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;
  logic           is_ovf;
  logic           is_zero;
  logic           special;
  logic           last_iter;

`ifdef DIV_SIGNED_EN
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
  logic signed_op;

  assign signed_op = op_is_signed(op);
  assign sign_a    = signed_op & op_a[W-1];
  assign sign_b    = signed_op & op_b[W-1];
  // Two's-complement negate; the most negative value maps onto its own
  // bit pattern, which read unsigned is the correct magnitude 2^(W-1).
  assign mag_a     = sign_a ? (~op_a + 1'b1) : op_a;
  assign mag_b     = sign_b ? (~op_b + 1'b1) : op_b;
  assign is_ovf    = signed_op && (op_a == MIN_NEG) && (&op_b);
`else
  logic unused_op_bit;

  // op[0] only distinguishes signed from unsigned, which this build folds
  // together.
  assign unused_op_bit = op[0];
  assign sign_a        = 1'b0;
  assign sign_b        = 1'b0;
  assign mag_a         = op_a;
  assign mag_b         = op_b;
  assign is_ovf        = 1'b0;
`endif

  assign is_zero   = (op_b == '0);
  assign special   = zero_reg | ovf_reg;
  assign last_iter = (count_reg == C'(W-1));

  alu_div_step #(.W(W)) u_step (
    .accum_in  (accum_reg[AW-2:0]),
    .divisor   (mag_b_reg),
    .accum_out (step_out)
  );

  // ---------------------------------------------------------------------------
  // Controller: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Controller: next state and status outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    dact       = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load       = 1'b1;
        dact       = 1'b1;
        busy       = 1'b1;
        state_next = special ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        dact = 1'b1;
        busy = 1'b1;
        if (last_iter) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        dact       = 1'b1;
        busy       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath.  Operands and flags are captured on the edge that accepts
  // start, so the initialised accumulator is already visible while load is
  // high.  Nothing changes in IDLE/DONE, which keeps results held until the
  // next accepted request.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      accum_reg   <= '0;
      count_reg   <= '0;
      mag_b_reg   <= '0;
      sbit_reg    <= 2'b00;
      zero_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
      res_sel_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            res_sel_reg <= op_is_rem(op);
            zero_reg    <= is_zero;
            ovf_reg     <= is_ovf;
            sbit_reg    <= {sign_a, sign_a ^ sign_b};
            mag_b_reg   <= mag_b;
            count_reg   <= '0;
            if (is_zero || is_ovf) begin
              // No iterations will run: park the raw dividend in the
              // remainder slot so the downstream result mux finds it there.
              accum_reg <= {1'b0, op_a, 1'b0, mag_a, 3'b000};
            end else begin
              accum_reg <= {{(W+2){1'b0}}, mag_a, 3'b000};
            end
          end
        end
        ST_RUN: begin
          count_reg <= count_reg + 1'b1;
          if (last_iter) begin
            // Final iteration also moves the remainder up one place so it
            // lands in [2W+3:W+4], the same slot the special cases use.
            accum_reg <= {step_out[AW-2:W+3], 1'b0, step_out[W+2:0]};
          end else begin
            accum_reg <= step_out;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign accum        = accum_reg;
  assign div_sbit     = sbit_reg;
  assign div_zero     = zero_reg;
  assign div_overflow = ovf_reg;
  assign div_res_sel  = res_sel_reg;

endmodule

// File: tb/tb_alu_div_core.sv
// -----------------------------------------------------------------------------
// tb_alu_div_core
// Directed vectors for alu_div_core (W = 32).  Expected results are entered
// by hand for both builds (with / without DIV_SIGNED_EN).  The stimulus
// process pushes each accepted request onto a queue; the monitor pops it when
// the DUT finishes (dact falls) and compares results, latency and the
// accumulator seen during the load pulse.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_div_core;

  localparam int W  = 32;
  localparam int C  = 6;
  localparam int AW = 2*W + 5;

  logic          clk = 1'b0;
  logic          a_rst;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          load;
  logic [AW-1:0] accum;
  logic [1:0]    div_sbit;
  logic          div_zero;
  logic          div_overflow;
  logic          div_res_sel;
  logic          dact;
  logic          busy;

  alu_div_core #(.W(W), .C(C)) dut (
    .clk          (clk),
    .a_rst        (a_rst),
    .start        (start),
    .op           (op),
    .op_a         (op_a),
    .op_b         (op_b),
    .load         (load),
    .accum        (accum),
    .div_sbit     (div_sbit),
    .div_zero     (div_zero),
    .div_overflow (div_overflow),
    .div_res_sel  (div_res_sel),
    .dact         (dact),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] mag_a;
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic [1:0]   sbit;
    logic         zero;
    logic         ovf;
    int           lat;
    logic         abort;
    int           start_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string what, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", what, act, exp);
    end
  endtask

  task automatic flag_fail(input string what);
    n_cmp++;
    n_fail++;
    $display("FAIL %s", what);
  endtask

  function automatic exp_t mk(input string name, input logic [1:0] op_v,
                              input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] mag_a, input logic [W-1:0] quo,
                              input logic [W-1:0] rem, input logic [1:0] sbit,
                              input logic zero, input logic ovf, input int lat);
    exp_t e;
    e.name = name; e.op = op_v; e.a = a; e.b = b; e.mag_a = mag_a;
    e.quo = quo; e.rem = rem; e.sbit = sbit; e.zero = zero; e.ovf = ovf;
    e.lat = lat; e.abort = 1'b0; e.start_cyc = 0;
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin
    logic          prev_dact = 1'b0;
    logic [AW-1:0] prev_accum = '0;
    logic [1:0]    prev_sbit = 2'b00;
    logic          prev_zero = 1'b0;
    logic          prev_ovf = 1'b0;
    logic          prev_rsel = 1'b0;
    exp_t          e;
    logic [AW-1:0] exp_acc;
    forever begin
      @(negedge clk);
      if (load === 1'b1) begin
        if (sb_q.size() == 0) begin
          flag_fail("load pulse with no request outstanding");
        end else begin
          e = sb_q[0];
          check({e.name, " load_time"}, AW'(cyc), AW'(e.start_cyc + 1));
          if (e.zero || e.ovf)
            exp_acc = {1'b0, e.a, 1'b0, e.mag_a, 3'b000};
          else
            exp_acc = {{(W+2){1'b0}}, e.mag_a, 3'b000};
          check({e.name, " load_accum"}, accum, exp_acc);
        end
      end
      if (prev_dact === 1'b1 && dact === 1'b0) begin
        if (sb_q.size() == 0) begin
          flag_fail("completion with no request outstanding");
        end else begin
          e = sb_q.pop_front();
          if (e.abort) begin
            check({e.name, " accum_after_reset"}, accum, '0);
            check({e.name, " flags_after_reset"},
                  AW'({div_sbit, div_zero, div_overflow, div_res_sel, load, busy}), '0);
            $display("[%0d] %s: aborted by reset, accum=0x%0h busy=%0b", cyc, e.name, accum, busy);
          end else begin
            exp_acc = {1'b0, e.rem, 1'b0, e.quo, 3'b000};
            check({e.name, " done_accum"}, prev_accum, exp_acc);
            check({e.name, " held_accum"}, accum, exp_acc);
            check({e.name, " sbit"}, AW'(prev_sbit), AW'(e.sbit));
            check({e.name, " zero"}, AW'(prev_zero), AW'(e.zero));
            check({e.name, " overflow"}, AW'(prev_ovf), AW'(e.ovf));
            check({e.name, " res_sel"}, AW'(prev_rsel), AW'(e.op[1]));
            check({e.name, " latency"}, AW'(cyc - 1 - e.start_cyc), AW'(e.lat));
            $display("[%0d] %s: op=%0b a=0x%0h b=0x%0h quo=0x%0h rem=0x%0h sbit=%0b zero=%0b ovf=%0b lat=%0d",
                     cyc, e.name, e.op, e.a, e.b, prev_accum[W+2:3], prev_accum[2*W+3:W+4],
                     prev_sbit, prev_zero, prev_ovf, cyc - 1 - e.start_cyc);
          end
        end
      end
      prev_dact  = dact;
      prev_accum = accum;
      prev_sbit  = div_sbit;
      prev_zero  = div_zero;
      prev_ovf   = div_overflow;
      prev_rsel  = div_res_sel;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (busy !== 1'b0) flag_fail("idle_timeout: busy stuck high");
  endtask

  task automatic issue(input exp_t e_in);
    exp_t e = e_in;
    wait_idle();
    @(negedge clk);
    #1;
    start = 1'b1;
    op    = e.op;
    op_a  = e.a;
    op_b  = e.b;
    e.start_cyc = cyc;
    sb_q.push_back(e);
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  exp_t vecs[$];

  initial begin
    exp_t e;
    a_rst = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    op_a  = '0;
    op_b  = '0;

    vecs.push_back(mk("divu_100_7",   2'b01, 32'd100,        32'd7,          32'd100,        32'd14,         32'd2,          2'b00, 1'b0, 1'b0, 34));
    vecs.push_back(mk("remu_5_0",     2'b11, 32'd5,          32'd0,          32'd5,          32'd5,          32'd5,          2'b00, 1'b1, 1'b0, 2));
    vecs.push_back(mk("divu_max_16",  2'b01, 32'hFFFFFFFF,   32'h10,         32'hFFFFFFFF,   32'h0FFFFFFF,   32'hF,          2'b00, 1'b0, 1'b0, 34));
    vecs.push_back(mk("divu_3_5",     2'b01, 32'd3,          32'd5,          32'd3,          32'd0,          32'd3,          2'b00, 1'b0, 1'b0, 34));
    vecs.push_back(mk("div_12_0",     2'b00, 32'd12,         32'd0,          32'd12,         32'd12,         32'd12,         2'b00, 1'b1, 1'b0, 2));
    vecs.push_back(mk("divu_min_m1",  2'b01, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          32'h80000000,   2'b00, 1'b0, 1'b0, 34));
`ifdef DIV_SIGNED_EN
    vecs.push_back(mk("div_m100_7",   2'b00, 32'hFFFFFF9C,   32'd7,          32'd100,        32'd14,         32'd2,          2'b11, 1'b0, 1'b0, 34));
    vecs.push_back(mk("div_min_m1",   2'b00, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'h80000000,   32'h80000000,   2'b10, 1'b0, 1'b1, 2));
    vecs.push_back(mk("div_m1_1",     2'b00, 32'hFFFFFFFF,   32'd1,          32'd1,          32'd1,          32'd0,          2'b11, 1'b0, 1'b0, 34));
    vecs.push_back(mk("rem_7_m2",     2'b10, 32'd7,          32'hFFFFFFFE,   32'd7,          32'd3,          32'd1,          2'b01, 1'b0, 1'b0, 34));
    vecs.push_back(mk("rem_min_3",    2'b10, 32'h80000000,   32'd3,          32'h80000000,   32'h2AAAAAAA,   32'd2,          2'b11, 1'b0, 1'b0, 34));
    vecs.push_back(mk("div_m8_0",     2'b00, 32'hFFFFFFF8,   32'd0,          32'd8,          32'd8,          32'hFFFFFFF8,   2'b11, 1'b1, 1'b0, 2));
`else
    vecs.push_back(mk("div_m100_7",   2'b00, 32'hFFFFFF9C,   32'd7,          32'hFFFFFF9C,   32'h24924916,   32'd2,          2'b00, 1'b0, 1'b0, 34));
    vecs.push_back(mk("div_min_m1",   2'b00, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          32'h80000000,   2'b00, 1'b0, 1'b0, 34));
    vecs.push_back(mk("div_m1_1",     2'b00, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'hFFFFFFFF,   32'd0,          2'b00, 1'b0, 1'b0, 34));
    vecs.push_back(mk("rem_7_m2",     2'b10, 32'd7,          32'hFFFFFFFE,   32'd7,          32'd0,          32'd7,          2'b00, 1'b0, 1'b0, 34));
    vecs.push_back(mk("rem_min_3",    2'b10, 32'h80000000,   32'd3,          32'h80000000,   32'h2AAAAAAA,   32'd2,          2'b00, 1'b0, 1'b0, 34));
    vecs.push_back(mk("div_m8_0",     2'b00, 32'hFFFFFFF8,   32'd0,          32'hFFFFFFF8,   32'hFFFFFFF8,   32'hFFFFFFF8,   2'b00, 1'b1, 1'b0, 2));
`endif

    // Reset state, checked while reset is asserted.
    repeat (2) @(negedge clk);
    check("reset accum", accum, '0);
    check("reset flags", AW'({div_sbit, div_zero, div_overflow, div_res_sel}), '0);
    check("reset status", AW'({load, dact, busy}), '0);
    #1;
    a_rst = 1'b0;

    foreach (vecs[i]) issue(vecs[i]);

    // A start pulse in the middle of RUN must be ignored.
    issue(mk("divu_1000_9", 2'b01, 32'd1000, 32'd9, 32'd1000, 32'd111, 32'd1, 2'b00, 1'b0, 1'b0, 34));
    repeat (5) @(negedge clk);
    #1;
    start = 1'b1;
    op    = 2'b11;
    op_a  = 32'd5;
    op_b  = 32'd0;
    @(negedge clk);
    #1;
    start = 1'b0;

    // Reset during RUN cycle 10: operation aborted, no DONE afterwards.
    e = mk("abort_100_7", 2'b01, 32'd100, 32'd7, 32'd100, 32'd14, 32'd2, 2'b00, 1'b0, 1'b0, 34);
    e.abort = 1'b1;
    issue(e);
    repeat (10) @(negedge clk);
    #1;
    a_rst = 1'b1;
    @(negedge clk);
    #1;
    a_rst = 1'b0;

    // Accepted immediately after reset: proves the core is back in IDLE.
    issue(mk("divu_100_7_post", 2'b01, 32'd100, 32'd7, 32'd100, 32'd14, 32'd2, 2'b00, 1'b0, 1'b0, 34));

    wait_idle();
    repeat (4) @(negedge clk);
    check("outstanding requests", AW'(sb_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
